// File: rtl/mpu_det_loader.sv
// Feeder/collector for the MPU determinant unit: packs a row-major element
// stream into the 5x5 matrix bus, waits a fixed settle window, returns det.
module mpu_det_loader #(
  parameter int DET_LATENCY = 8,
  parameter int MAX_SIZE    = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cfg_valid,
  input  logic [7:0]   cfg_size,
  output logic         cfg_ready,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [0:199] matrix,
  output logic [7:0]   det_size,
  input  logic [7:0]   det_result,
  output logic         res_valid,
  output logic [7:0]   res_data,
  input  logic         res_ready,
  output logic         busy,
  output logic         error
);

  localparam int CW = $clog2(DET_LATENCY + 1);
  localparam logic signed [7:0] MAXS = 8'(MAX_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [2:0]    size, row, col, sm1;
  logic [CW-1:0] cnt;
  logic [7:0]    wbase;
  logic          cfg_ok;

  assign cfg_ok    = ($signed(cfg_size) > 8'sd0) && ($signed(cfg_size) <= MAXS);
  assign sm1       = size - 3'd1;
  // bit offset of (row,col): row*40 + col*8, max 192 fits in 8 bits
  assign wbase     = {row, 5'b0} + {2'b0, row, 3'b0} + {2'b0, col, 3'b0};
  assign cfg_ready = (state == S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      matrix    <= '0;
      det_size  <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      error     <= 1'b0;
      size      <= '0;
      row       <= '0;
      col       <= '0;
      cnt       <= '0;
    end else begin
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            if (cfg_ok) begin
              size   <= cfg_size[2:0];
              matrix <= '0;
              row    <= '0;
              col    <= '0;
              state  <= S_LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            matrix[wbase +: 8] <= in_data;
            if (col == sm1) begin
              col <= '0;
              row <= row + 3'd1;
              if (row == sm1) begin
                cnt      <= CW'(DET_LATENCY);
                det_size <= {5'b0, size};
                state    <= S_WAIT;
              end
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        S_WAIT: begin
          // capture lands exactly DET_LATENCY edges after the last element
          if (cnt == CW'(1)) begin
            res_data  <= det_result;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            det_size  <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mpu_det_loader.md
Name: mpu_det_loader

Overview:
- Upstream feeder and result collector for the MPU determinant unit.
- Accepts a matrix order, then a row-major stream of signed 8-bit elements, and packs them into the 200-bit 5x5 matrix bus with zero padding.
- Holds matrix and size stable for a fixed settle window, captures the 8-bit determinant and returns it over a valid/ready result handshake.
- Sits between the host-side command/data path and the determinant unit.

Parameters:
- DET_LATENCY, 8: cycles the matrix/size are held stable before det_result is sampled; must be >= 2 and >= the determinant unit's worst-case latency.
- MAX_SIZE, 5: largest legal matrix order. Fixed by the 5x5 bus.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  matrix order offered
- cfg_size  in  8  signed matrix order, legal range 1..5
- cfg_ready  out  1  high only in IDLE
- in_valid  in  1  element offered
- in_data  in  8  signed element, row-major order
- in_ready  out  1  high only in LOAD
- matrix  out  200  packed matrix, ascending range 0:199; element (r,c) is at [(r*40 + c*8) +: 8], so (0,0) is the most significant byte
- det_size  out  8  order driven to the determinant unit
- det_result  in  8  signed determinant from the determinant unit
- res_valid  out  1  result available
- res_data  out  8  captured signed determinant
- res_ready  in  1  consumer accepts the result
- busy  out  1  high in any state other than IDLE
- error  out  1  one-cycle pulse when a cfg_size is rejected

Behaviour:
- States are IDLE, LOAD, WAIT and DONE.
- Reset: state=IDLE; matrix=0; det_size=0; res_data=0; res_valid=0; error=0; internal counters=0. Reset overrides every state, including mid-LOAD and mid-WAIT. No partial result is ever emitted after reset.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid with cfg_size in 1..5: latch size, clear matrix to 0, set row=col=0, and go to LOAD on the next edge.
  - On cfg_valid with cfg_size of 0, negative, or >5: pulse error for exactly 1 cycle and stay in IDLE. Nothing else changes.
- LOAD:
  - in_ready=1. An element is accepted on any cycle with in_valid=1.
  - The accepted byte is written to the (row,col) slot.
  - col increments; when col==size-1, col wraps to 0 and row increments.
  - Positions with row>=size or col>=size are never written and stay 0.
  - cfg_valid is ignored while in LOAD.
  - When the size*size-th element is accepted: go to WAIT, load the wait counter with DET_LATENCY, and drive det_size=size.
  - Gaps in in_valid stall LOAD indefinitely; there is no timeout.
- WAIT:
  - matrix and det_size are held constant.
  - The counter decrements each cycle.
  - On the cycle the counter reaches 1: res_data<=det_result, res_valid<=1, and go to DONE.
  - Total latency is exactly DET_LATENCY cycles from the last element acceptance edge to res_valid high.
- DONE:
  - res_valid and res_data are held until res_ready=1.
  - On that edge: res_valid<=0, det_size<=0, go to IDLE. matrix keeps its value until the next accepted cfg.
  - res_ready asserted outside DONE is ignored.
  - A new cfg cannot be accepted in the same cycle the result handshake completes; the earliest acceptance is the following cycle.
- Arithmetic: no arithmetic is performed on elements. Bytes pass through bit-exact with sign preserved. det_result is captured unmodified; 8-bit wrap is the determinant unit's responsibility.
- Throughput: one matrix in flight. Minimum period is 1 + size*size + DET_LATENCY + 1 cycles.

Test Plan:
- Bench det model: exact determinant truncated to 8 bits, updated combinationally from matrix and det_size.
- 2x2: cfg_size=2, then stream 3,1,2,4 back-to-back.
  - matrix bytes: (0,0)=3, (0,1)=1, (1,0)=2, (1,1)=4, all others 0.
  - res_valid rises DET_LATENCY cycles after the last element; res_data=10.
- 3x3 identity streamed with a 1-cycle in_valid gap after every element.
  - All 9 elements are placed correctly, unused slots are 0, res_data=1.
- 1x1: stream -5.
  - matrix[0 +: 8]=8'hFB, res_data=8'hFB.
  - Hold res_ready low for 10 cycles: res_valid and res_data stay stable, and cfg_ready stays 0 throughout.
- Illegal sizes: cfg_size=6, then 0, then 8'hFF.
  - Each produces a single-cycle error pulse.
  - State stays IDLE, in_ready stays 0, matrix is unchanged.
- Reset mid-operation:
  - Assert reset after 7 of 25 elements of a 5x5 load: next cycle state=IDLE, matrix=0, busy=0, no res_valid.
  - A subsequent full 5x5 load completes correctly.
